// File: rtl/sobel_edge_3x3_8bit_if.sv
// Bus bundle for sobel_edge_3x3_8bit: 3x3 window plus syncs in, edge/gray plus delayed syncs out.
// master = window source / result sink, slave = the Sobel block.
interface sobel_edge_3x3_8bit_if;
    logic       matrix_frame_vsync;
    logic       matrix_frame_href;
    logic       matrix_frame_clken;
    logic [7:0] matrix_p11, matrix_p12, matrix_p13;
    logic [7:0] matrix_p21, matrix_p22, matrix_p23;
    logic [7:0] matrix_p31, matrix_p32, matrix_p33;
    logic [7:0] threshold;
    logic       post_frame_vsync;
    logic       post_frame_href;
    logic       post_frame_clken;
    logic       post_img_bit;
    logic [7:0] post_img_y;

    modport master (
        output matrix_frame_vsync, matrix_frame_href, matrix_frame_clken,
        output matrix_p11, matrix_p12, matrix_p13,
        output matrix_p21, matrix_p22, matrix_p23,
        output matrix_p31, matrix_p32, matrix_p33,
        output threshold,
        input  post_frame_vsync, post_frame_href, post_frame_clken,
        input  post_img_bit, post_img_y
    );

    modport slave (
        input  matrix_frame_vsync, matrix_frame_href, matrix_frame_clken,
        input  matrix_p11, matrix_p12, matrix_p13,
        input  matrix_p21, matrix_p22, matrix_p23,
        input  matrix_p31, matrix_p32, matrix_p33,
        input  threshold,
        output post_frame_vsync, post_frame_href, post_frame_clken,
        output post_img_bit, post_img_y
    );
endinterface

// File: rtl/sobel_edge_3x3_8bit.sv
// 3-stage Sobel edge detector on a 3x3 luma window with border suppression.
// Optional macro SOBEL_GRAY_OUT_EN: post_img_y carries the saturated gradient
// magnitude instead of the replicated edge bit.
module sobel_edge_3x3_8bit #(
    parameter int EDGE_POL = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    sobel_edge_3x3_8bit_if.slave bus
);

    // Weighted column/row sum a + 2*b + c, widened to 10 bits.
    function automatic logic [9:0] wsum(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    // Centre tap carries zero weight in both kernels.
    logic unused_p22;
    assign unused_p22 = ^bus.matrix_p22;

    logic        vsync_d, href_d;
    logic [11:0] col_cnt, row_cnt;
    logic        vsync_rise, href_fall, border_in;

    assign vsync_rise = bus.matrix_frame_vsync & ~vsync_d;
    assign href_fall  = href_d & ~bus.matrix_frame_href;
    assign border_in  = (col_cnt < 12'd2) || (row_cnt < 12'd2);

    // Column/row position of the incoming window; vsync clear wins over row increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d <= 1'b0;
            href_d  <= 1'b0;
            col_cnt <= '0;
            row_cnt <= '0;
        end else begin
            vsync_d <= bus.matrix_frame_vsync;
            href_d  <= bus.matrix_frame_href;
            if (!bus.matrix_frame_href)
                col_cnt <= '0;
            else if (bus.matrix_frame_clken && col_cnt != 12'hFFF)
                col_cnt <= col_cnt + 12'd1;
            if (vsync_rise)
                row_cnt <= '0;
            else if (href_fall && row_cnt != 12'hFFF)
                row_cnt <= row_cnt + 12'd1;
        end
    end

    logic [9:0] gx_p, gx_n, gy_p, gy_n;
    logic       border1;

    // Stage 1: positive/negative halves of both Sobel kernels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx_p    <= '0;
            gx_n    <= '0;
            gy_p    <= '0;
            gy_n    <= '0;
            border1 <= 1'b0;
        end else begin
            gx_p    <= wsum(bus.matrix_p13, bus.matrix_p23, bus.matrix_p33);
            gx_n    <= wsum(bus.matrix_p11, bus.matrix_p21, bus.matrix_p31);
            gy_p    <= wsum(bus.matrix_p31, bus.matrix_p32, bus.matrix_p33);
            gy_n    <= wsum(bus.matrix_p11, bus.matrix_p12, bus.matrix_p13);
            border1 <= border_in;
        end
    end

    logic [9:0] abs_gx, abs_gy;
    logic       border2;

    // Stage 2: absolute differences without wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abs_gx  <= '0;
            abs_gy  <= '0;
            border2 <= 1'b0;
        end else begin
            abs_gx  <= (gx_p >= gx_n) ? (gx_p - gx_n) : (gx_n - gx_p);
            abs_gy  <= (gy_p >= gy_n) ? (gy_p - gy_n) : (gy_n - gy_p);
            border2 <= border1;
        end
    end

    logic [10:0] mag;
    logic        edge_q;

    assign mag = {1'b0, abs_gx} + {1'b0, abs_gy};

    // Stage 3: threshold decision, suppressed on incomplete windows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            edge_q <= 1'b0;
        else
            edge_q <= ~border2 & (mag > {3'b000, bus.threshold});
    end

`ifdef SOBEL_GRAY_OUT_EN
    logic [7:0] mag_sat;

    // Stage 3: saturated gradient magnitude, zeroed on incomplete windows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mag_sat <= '0;
        else if (border2)
            mag_sat <= '0;
        else
            mag_sat <= (mag > 11'd255) ? 8'hFF : mag[7:0];
    end
`endif

    logic [2:0] sync1, sync2, sync3;

    // Sync delay line {vsync, href, clken}, matched to the 3-stage datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= {bus.matrix_frame_vsync, bus.matrix_frame_href, bus.matrix_frame_clken};
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    logic pol_bit;
    assign pol_bit = (EDGE_POL != 0) ? edge_q : ~edge_q;

    assign bus.post_frame_vsync = sync3[2];
    assign bus.post_frame_href  = sync3[1];
    assign bus.post_frame_clken = sync3[0];
    assign bus.post_img_bit     = sync3[1] & pol_bit;
`ifdef SOBEL_GRAY_OUT_EN
    assign bus.post_img_y       = sync3[1] ? mag_sat : 8'h00;
`else
    assign bus.post_img_y       = {8{bus.post_img_bit}};
`endif

endmodule

// File: tb/tb_sobel_edge_3x3_8bit.sv
// Directed self-checking bench: one DUT with EDGE_POL=1, one with EDGE_POL=0, shared stimulus.
module tb_sobel_edge_3x3_8bit;

`ifdef SOBEL_GRAY_OUT_EN
    localparam bit GRAY = 1'b1;
`else
    localparam bit GRAY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sobel_edge_3x3_8bit_if bus();
    sobel_edge_3x3_8bit_if bus_n();

    assign bus_n.matrix_frame_vsync = bus.matrix_frame_vsync;
    assign bus_n.matrix_frame_href  = bus.matrix_frame_href;
    assign bus_n.matrix_frame_clken = bus.matrix_frame_clken;
    assign bus_n.matrix_p11 = bus.matrix_p11;
    assign bus_n.matrix_p12 = bus.matrix_p12;
    assign bus_n.matrix_p13 = bus.matrix_p13;
    assign bus_n.matrix_p21 = bus.matrix_p21;
    assign bus_n.matrix_p22 = bus.matrix_p22;
    assign bus_n.matrix_p23 = bus.matrix_p23;
    assign bus_n.matrix_p31 = bus.matrix_p31;
    assign bus_n.matrix_p32 = bus.matrix_p32;
    assign bus_n.matrix_p33 = bus.matrix_p33;
    assign bus_n.threshold  = bus.threshold;

    sobel_edge_3x3_8bit #(.EDGE_POL(1)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    sobel_edge_3x3_8bit #(.EDGE_POL(0)) dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_win(input logic [7:0] a11, input logic [7:0] a12, input logic [7:0] a13,
                           input logic [7:0] a21, input logic [7:0] a22, input logic [7:0] a23,
                           input logic [7:0] a31, input logic [7:0] a32, input logic [7:0] a33);
        bus.matrix_p11 = a11; bus.matrix_p12 = a12; bus.matrix_p13 = a13;
        bus.matrix_p21 = a21; bus.matrix_p22 = a22; bus.matrix_p23 = a23;
        bus.matrix_p31 = a31; bus.matrix_p32 = a32; bus.matrix_p33 = a33;
    endtask

    task automatic start_frame();
        bus.matrix_frame_vsync = 1'b1;
        step();
        bus.matrix_frame_vsync = 1'b0;
        step();
    endtask

    task automatic skip_line();
        bus.matrix_frame_href  = 1'b1;
        bus.matrix_frame_clken = 1'b1;
        repeat (10) step();
        bus.matrix_frame_href  = 1'b0;
        bus.matrix_frame_clken = 1'b0;
        repeat (4) step();
    endtask

    task automatic goto_row2();
        start_frame();
        skip_line();
        skip_line();
    endtask

    // Runs one 10-pixel line and samples both DUTs while pixel 4 is at the output.
    task automatic run_line_sample(output logic b0, output logic [7:0] y0,
                                   output logic b1, output logic [7:0] y1);
        bus.matrix_frame_href  = 1'b1;
        bus.matrix_frame_clken = 1'b1;
        b0 = 1'b0; y0 = '0; b1 = 1'b0; y1 = '0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (c == 6) begin
                b0 = bus.post_img_bit;   y0 = bus.post_img_y;
                b1 = bus_n.post_img_bit; y1 = bus_n.post_img_y;
            end
        end
        bus.matrix_frame_href  = 1'b0;
        bus.matrix_frame_clken = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_reset();
        logic [11:0] o0;
        total++;
        o0 = {bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_clken, bus.post_img_bit, bus.post_img_y};
        if (o0 !== 12'h000) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=000", o0);
        end
        total++;
        if ({bus_n.post_img_bit, bus_n.post_img_y} !== 9'h000) begin
            bad++;
            $display("FAIL reset_outputs_pol0 got=%h exp=000", {bus_n.post_img_bit, bus_n.post_img_y});
        end
    endtask

    task automatic test_uniform();
        logic b0, b1;
        logic [7:0] y0, y1;
        set_win(100, 100, 100, 100, 100, 100, 100, 100, 100);
        bus.threshold = 8'd40;
        goto_row2();
        run_line_sample(b0, y0, b1, y1);
        total++;
        if ({b0, y0} !== 9'h000) begin
            bad++;
            $display("FAIL uniform bit/y got=%b/%h exp=0/00", b0, y0);
        end
        total++;
        if ({b1, y1} !== {1'b1, (GRAY ? 8'h00 : 8'hFF)}) begin
            bad++;
            $display("FAIL uniform_pol0 bit/y got=%b/%h exp=1/%h", b1, y1, GRAY ? 8'h00 : 8'hFF);
        end
    endtask

    task automatic test_strong();
        logic b0, b1;
        logic [7:0] y0, y1;
        set_win(0, 0, 255, 0, 0, 255, 0, 0, 255);
        bus.threshold = 8'd40;
        goto_row2();
        run_line_sample(b0, y0, b1, y1);
        total++;
        if ({b0, y0} !== 9'h1FF) begin
            bad++;
            $display("FAIL strong bit/y got=%b/%h exp=1/ff", b0, y0);
        end
        total++;
        if (b1 !== 1'b0) begin
            bad++;
            $display("FAIL strong_pol0 bit got=%b exp=0", b1);
        end
    endtask

    task automatic test_threshold();
        logic b0, b1;
        logic [7:0] y0, y1;
        set_win(0, 0, 0, 0, 0, 20, 0, 0, 0);
        bus.threshold = 8'd40;
        goto_row2();
        run_line_sample(b0, y0, b1, y1);
        total++;
        if ({b0, y0} !== {1'b0, (GRAY ? 8'd40 : 8'h00)}) begin
            bad++;
            $display("FAIL thr_equal bit/y got=%b/%h exp=0/%h", b0, y0, GRAY ? 8'd40 : 8'h00);
        end
        bus.threshold = 8'd39;
        run_line_sample(b0, y0, b1, y1);
        total++;
        if ({b0, y0} !== {1'b1, (GRAY ? 8'd40 : 8'hFF)}) begin
            bad++;
            $display("FAIL thr_below bit/y got=%b/%h exp=1/%h", b0, y0, GRAY ? 8'd40 : 8'hFF);
        end
    endtask

    // Negative-side gradients: p11=10 -> |gx|=10,|gy|=10; p21=30 -> |gx|=60.
    task automatic test_gradient_dirs();
        logic b0, b1;
        logic [7:0] y0, y1;
        set_win(10, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.threshold = 8'd19;
        goto_row2();
        run_line_sample(b0, y0, b1, y1);
        total++;
        if ({b0, y0} !== {1'b1, (GRAY ? 8'd20 : 8'hFF)}) begin
            bad++;
            $display("FAIL corner_grad bit/y got=%b/%h exp=1/%h", b0, y0, GRAY ? 8'd20 : 8'hFF);
        end
        set_win(0, 0, 0, 30, 0, 0, 0, 0, 0);
        bus.threshold = 8'd60;
        run_line_sample(b0, y0, b1, y1);
        total++;
        if ({b0, y0} !== {1'b0, (GRAY ? 8'd60 : 8'h00)}) begin
            bad++;
            $display("FAIL left_grad bit/y got=%b/%h exp=0/%h", b0, y0, GRAY ? 8'd60 : 8'h00);
        end
    endtask

    task automatic test_border();
        logic exp_b;
        set_win(0, 0, 255, 0, 0, 255, 0, 0, 255);
        bus.threshold = 8'd40;
        start_frame();
        for (int r = 0; r < 3; r++) begin
            bus.matrix_frame_href  = 1'b1;
            bus.matrix_frame_clken = 1'b1;
            for (int c = 0; c < 10; c++) begin
                step();
                if (c >= 2) begin
                    exp_b = (r >= 2) && (c - 2 >= 2);
                    total++;
                    if (bus.post_img_bit !== exp_b) begin
                        bad++;
                        $display("FAIL border r%0d p%0d got=%b exp=%b", r, c - 2, bus.post_img_bit, exp_b);
                    end
                end
            end
            bus.matrix_frame_href  = 1'b0;
            bus.matrix_frame_clken = 1'b0;
            repeat (4) step();
        end
    endtask

    task automatic test_back_to_back();
        logic exp_b;
        bus.threshold = 8'd40;
        set_win(0, 0, 0, 0, 0, 0, 0, 0, 0);
        goto_row2();
        bus.matrix_frame_href  = 1'b1;
        bus.matrix_frame_clken = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c % 2 == 1) set_win(0, 0, 255, 0, 0, 255, 0, 0, 255);
            else            set_win(0, 0, 0, 0, 0, 0, 0, 0, 0);
            step();
            if (c >= 4) begin
                exp_b = ((c - 2) % 2 == 1);
                total++;
                if (bus.post_img_bit !== exp_b) begin
                    bad++;
                    $display("FAIL b2b p%0d got=%b exp=%b", c - 2, bus.post_img_bit, exp_b);
                end
            end
        end
        bus.matrix_frame_href  = 1'b0;
        bus.matrix_frame_clken = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_syncs();
        logic [2:0] hist [0:39];
        logic [2:0] got;
        set_win(0, 0, 255, 0, 0, 255, 0, 0, 255);
        for (int c = 0; c < 40; c++) begin
            hist[c] = 3'($urandom_range(0, 7));
            {bus.matrix_frame_vsync, bus.matrix_frame_href, bus.matrix_frame_clken} = hist[c];
            step();
            if (c >= 2) begin
                got = {bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_clken};
                total++;
                if (got !== hist[c - 2]) begin
                    bad++;
                    $display("FAIL sync_delay c%0d got=%b exp=%b", c, got, hist[c - 2]);
                end
                if (!bus_n.post_frame_href) begin
                    total++;
                    if ({bus_n.post_img_bit, bus_n.post_img_y} !== 9'h000) begin
                        bad++;
                        $display("FAIL pol0_href_low c%0d got=%b/%h exp=0/00", c, bus_n.post_img_bit, bus_n.post_img_y);
                    end
                end
            end
        end
        {bus.matrix_frame_vsync, bus.matrix_frame_href, bus.matrix_frame_clken} = 3'b000;
        repeat (4) step();
    endtask

    task automatic test_reset_mid();
        logic b0, b1;
        logic [7:0] y0, y1;
        set_win(0, 0, 255, 0, 0, 255, 0, 0, 255);
        bus.threshold = 8'd40;
        goto_row2();
        bus.matrix_frame_href  = 1'b1;
        bus.matrix_frame_clken = 1'b1;
        repeat (6) step();
        total++;
        if (bus.post_img_bit !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_edge got=%b exp=1", bus.post_img_bit);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_clken, bus.post_img_bit, bus.post_img_y} !== 12'h000) begin
            bad++;
            $display("FAIL mid_reset_outputs got=%h exp=000",
                     {bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_clken, bus.post_img_bit, bus.post_img_y});
        end
        bus.matrix_frame_href  = 1'b0;
        bus.matrix_frame_clken = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        repeat (3) step();
        for (int r = 0; r < 3; r++) begin
            run_line_sample(b0, y0, b1, y1);
            total++;
            if (b0 !== (r >= 2)) begin
                bad++;
                $display("FAIL post_reset_row%0d got=%b exp=%b", r, b0, (r >= 2));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {bus.matrix_frame_vsync, bus.matrix_frame_href, bus.matrix_frame_clken} = 3'b000;
        set_win(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.threshold = 8'd40;
        step();
        step();
        test_reset();
        rst_n = 1'b1;
        step();
        test_uniform();
        test_strong();
        test_threshold();
        test_gradient_dirs();
        test_border();
        test_back_to_back();
        test_syncs();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sobel_edge_3x3_8bit.md
SOBEL_EDGE_3X3_8BIT -- requirements
Module: sobel_edge_3x3_8bit

Interface
REQ-001 SHALL have parameter EDGE_POL, default 1, meaning edge pixel output value (1: edge=1/background=0; 0: inverted).
REQ-002 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports matrix_frame_vsync, matrix_frame_href, matrix_frame_clken  input  1 each  window sync/valid from the 3x3 matrix stage.
REQ-005 SHALL have ports matrix_p11..matrix_p33  input  8 each  3x3 luma window (row 1 oldest line, column 3 newest pixel).
REQ-006 SHALL have port threshold  input  8  edge threshold, sampled every cycle.
REQ-007 SHALL have ports post_frame_vsync, post_frame_href, post_frame_clken  output  1 each  input syncs delayed 3 cycles.
REQ-008 SHALL have port post_img_bit  output  1  edge decision.
REQ-009 SHALL have port post_img_y  output  8  gray output (see Configuration).

Function
REQ-010 Stage 1 SHALL register unsigned 10-bit sums: gx_p=p13+2*p23+p33, gx_n=p11+2*p21+p31, gy_p=p31+2*p32+p33, gy_n=p11+2*p12+p13.
REQ-011 Stage 2 SHALL register 10-bit abs_gx=|gx_p-gx_n| and abs_gy=|gy_p-gy_n|, no wrap.
REQ-012 Stage 3 SHALL form 11-bit mag=abs_gx+abs_gy, register mag_sat=min(mag,255) and edge=(mag>threshold) (strict greater-than).
REQ-013 Pipeline SHALL advance every clock regardless of clken; latency input window -> post_img_* = 3 cycles, matching post_frame_* delay exactly.
REQ-014 Column counter (12 bit) SHALL increment on each cycle with matrix_frame_href&matrix_frame_clken, clear when href low; saturate at 4095.
REQ-015 Row counter (12 bit) SHALL increment on each falling edge of matrix_frame_href, clear on rising edge of matrix_frame_vsync; saturate at 4095.
REQ-016 Border flag SHALL be set for column count <2 or row count <2 (incomplete window) and travel with the pipeline; when set, edge SHALL be forced 0 and mag_sat forced 0.
REQ-017 post_img_bit SHALL equal edge when EDGE_POL=1, ~edge when EDGE_POL=0.
REQ-018 When delayed href (post_frame_href) is low, post_img_bit and post_img_y SHALL be 0 regardless of EDGE_POL.
REQ-019 Simultaneous vsync rising edge and href falling edge SHALL clear the row counter (clear wins).

Reset
REQ-020 On rst_n low all pipeline registers, counters, sync delay lines and outputs SHALL be 0 immediately; first valid output 3 cycles after first valid input following deassertion.
REQ-021 Reset mid-frame SHALL restart counters; rows until next vsync rising edge count from 0 (border suppression reapplied).

Configuration
REQ-022 Macro SOBEL_GRAY_OUT_EN: defined -> post_img_y = mag_sat (gradient magnitude); undefined -> post_img_y = {8{post_img_bit}} and stage-3 mag_sat register not synthesised.

Verification
REQ-023 Uniform window all 100, threshold 40, row/col>=2 -> mag 0, post_img_bit=0, post_img_y=0 (both builds).
REQ-024 p13=p23=p33=255, rest 0, threshold 40 -> mag 1020 saturated, post_img_bit=1, post_img_y=255 (GRAY_OUT_EN) or 8'hFF.
REQ-025 p23=20, rest 0: threshold 40 -> post_img_bit=0; threshold 39 -> post_img_bit=1; post_img_y=40 with GRAY_OUT_EN.
REQ-026 Strong edge window on first two columns and first two rows of a frame -> post_img_bit=0; from column 2 of row 2 -> 1.
REQ-027 Toggle syncs with random pattern -> post_frame_* equal inputs delayed exactly 3 cycles; EDGE_POL=0 with href low -> post_img_bit=0.
REQ-028 Assert rst_n low mid-line with edge active -> all outputs 0 same cycle; after release rows 0-1 suppressed until vsync.
